// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and line levels for the serial link
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - valid/ready word handshake into the serial transmitter
interface serial_tx_if #(
   parameter int DATA_W = 8
);

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - per-bit clock counter with a one-cycle bit_done pulse
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;

   // bit_done marks the last clock of a bit period; with CLKS_PER_BIT=1 it is high every cycle
   assign bit_done = (clk_cnt == LAST_CLK);

   // count clocks within a bit, wrapping at each bit boundary or on restart
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_cnt <= '0;
      end else if (restart || bit_done) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - UART-style serial transmitter, optional parity bit via SERIAL_TX_PARITY_EN
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   serial_tx_if.slave   bus,
   output logic         tx_line,
   output logic         busy
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_idx_q, bit_idx_d;
   logic              tx_line_d;
   logic              tx_ready_q;
   logic              transfer;
   logic              restart;
   logic              bit_done;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   assign bus.tx_ready = tx_ready_q;
   assign transfer     = bus.tx_valid && tx_ready_q;

   // timer is held at zero while idle and realigned whenever the state changes
   assign restart = (state_q == IDLE) || (state_d != state_q);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .bit_done (bit_done)
   );

   // next-state, shift register and bit index update
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d   = START;
               shift_d   = bus.tx_data;
               bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
               parity_d  = ^bus.tx_data;
`endif
            end
         end
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // line level for the upcoming cycle, so the registered tx_line lines up with the new state
   always_comb begin
      tx_line_d = IDLE_LEVEL;
      case (state_d)
         START:   tx_line_d = START_LEVEL;
         DATA:    tx_line_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  tx_line_d = parity_d;
`endif
         STOP:    tx_line_d = STOP_LEVEL;
         default: tx_line_d = IDLE_LEVEL;
      endcase
   end

   // state and registered outputs; reset forces the line idle without waiting for a clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         tx_line    <= IDLE_LEVEL;
         tx_ready_q <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         tx_line    <= tx_line_d;
         tx_ready_q <= (state_d == IDLE);
         busy       <= (state_d != IDLE);
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   // parity is captured with the word so later tx_data changes cannot affect it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
module tb_serial_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB = DW + 2 + PB;

   logic clk = 1'b0;
   logic reset;
   logic tx_line, busy;
   logic tx_line1, busy1;

   int n_checks = 0;
   int n_fail   = 0;

   serial_tx_if #(.DATA_W(DW)) bus ();
   serial_tx_if #(.DATA_W(DW)) bus1 ();

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .tx_line (tx_line),
      .busy    (busy)
   );

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus1),
      .tx_line (tx_line1),
      .busy    (busy1)
   );

   always #5 clk = ~clk;

   // expected line level per frame bit: start, data LSB first, [parity], stop
   function automatic logic [15:0] frame_bits(input logic [7:0] d);
      logic [15:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   task automatic check_idle(input string name);
      n_checks++;
      if ({tx_line, bus.tx_ready, busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL %s: line/ready/busy got %b%b%b expected 110", name, tx_line, bus.tx_ready, busy);
      end
   endtask

   // called just after the transfer edge; checks every cycle of the frame
   task automatic watch_frame(input logic [7:0] d, input string name, input bit inject);
      logic [15:0] f;
      f = frame_bits(d);
      for (int c = 0; c < NB * CPB; c++) begin
         @(negedge clk);
         n_checks++;
         if (tx_line !== f[c/CPB]) begin
            n_fail++;
            $display("FAIL %s line cycle %0d: got %b expected %b", name, c, tx_line, f[c/CPB]);
         end
         n_checks++;
         if (busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy/ready cycle %0d: got %b/%b expected 1/0", name, c, busy, bus.tx_ready);
         end
         if (inject && c == 12) begin
            bus.tx_data  = 8'hFF;
            bus.tx_valid = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus1.tx_valid = 1'b0;
      bus1.tx_data  = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.tx_valid = 1'($urandom_range(0, 1));
         bus.tx_data  = 8'($urandom);
         #1;
         check_idle("reset held");
      end
      @(posedge clk);
      #3;
      bus.tx_valid = 1'b0;
      reset        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_idle("reset release first edge");
      n_checks++;
      if ({tx_line1, bus1.tx_ready, busy1} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset dut1: got %b%b%b expected 110", tx_line1, bus1.tx_ready, busy1);
      end
   endtask

   task automatic test_single_frame();
      @(negedge clk);
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h5A;
      watch_frame(8'hA5, "single", 1'b0);
      @(negedge clk);
      check_idle("single end");
   endtask

   task automatic test_ignored_request();
      @(negedge clk);
      bus.tx_data  = 8'h5C;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      watch_frame(8'h5C, "ignored busy", 1'b1);
      @(negedge clk);
      check_idle("ignored gap");
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      watch_frame(8'hFF, "ignored ff", 1'b0);
      @(negedge clk);
      check_idle("ignored end");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_data  = 8'hFF;
      watch_frame(8'h00, "b2b first", 1'b0);
      @(negedge clk);
      check_idle("b2b idle gap");
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      watch_frame(8'hFF, "b2b second", 1'b0);
      @(negedge clk);
      check_idle("b2b end");
   endtask

   task automatic test_mid_reset();
      // reset during the start bit: line must jump from 0 to 1 without a clock edge
      @(negedge clk);
      bus.tx_data  = 8'h3C;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b0) begin
         n_fail++;
         $display("FAIL mid reset start bit: got %b expected 0", tx_line);
      end
      #2;
      reset = 1'b0;
      #1;
      check_idle("async reset in start");
      @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      // reset during data bit 3 of 8'h3C
      bus.tx_data  = 8'h3C;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid reset data bit3: got line %b busy %b expected 1 1", tx_line, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      check_idle("async reset in data");
      @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      check_idle("after mid reset release");
      bus.tx_data  = 8'h96;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      watch_frame(8'h96, "post reset frame", 1'b0);
      @(negedge clk);
      check_idle("post reset end");
   endtask

   task automatic test_one_clk_per_bit();
      logic [15:0] f;
      f = frame_bits(8'h07);
      @(negedge clk);
      bus1.tx_data  = 8'h07;
      bus1.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus1.tx_valid = 1'b0;
      for (int c = 0; c < NB; c++) begin
         @(negedge clk);
         n_checks++;
         if (tx_line1 !== f[c] || busy1 !== 1'b1 || bus1.tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cpb1 cycle %0d: got line %b busy %b ready %b expected %b 1 0",
                     c, tx_line1, busy1, bus1.tx_ready, f[c]);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({tx_line1, bus1.tx_ready, busy1} !== 3'b110) begin
         n_fail++;
         $display("FAIL cpb1 end: got %b%b%b expected 110", tx_line1, bus1.tx_ready, busy1);
      end
   endtask

   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      test_reset();
      test_single_frame();
      test_ignored_request();
      test_back_to_back();
      test_mid_reset();
      test_one_clk_per_bit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out UART-style transmitter. It is the sending end of the lab's single-wire serial link, which the flip-flop/shift-register receiver path samples. It accepts a DATA_W-bit word over a valid/ready handshake. It then drives a framed bit stream on one line, holding each bit for CLKS_PER_BIT clocks.

Parameters:
DATA_W, 8, payload bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_valid  input  1  upstream has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx_line  output  1  serial output; idle level 1
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (reset=0, asynchronous, regardless of clk):
  - state=IDLE; tx_line=1; tx_ready=1; busy=0; shift register=0; bit and clock counters=0.
  - Deassertion takes effect on the next rising clk.
  - Reset asserted mid-frame aborts the frame immediately; tx_line returns to 1 without waiting for an edge.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE; it is a registered output, not combinational from tx_valid.
  - tx_data is latched into the shift register at the transfer edge. Later changes on tx_data do not affect the frame.
  - tx_valid while tx_ready=0 is ignored; there is no queueing. Upstream holds tx_valid until accepted.
- Frame format, LSB first: start bit 0, then DATA_W data bits, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: tx_line=1. On transfer, go to START.
  - START: tx_line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_line=shift[0]. After CLKS_PER_BIT cycles, shift right by one and increment the index. When the index reaches DATA_W-1 and its bit period ends, go to STOP (or PARITY when enabled).
  - STOP: tx_line=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: tx_line falls 1 cycle after the transfer edge (the first registered output).
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
- tx_ready returns to 1 in the cycle after the final stop-bit cycle. Back-to-back frames are allowed: one IDLE cycle minimum between the stop bit and the next start bit.
- Counter widths: clock counter $clog2(CLKS_PER_BIT) bits, minimum 1; bit counter $clog2(DATA_W) bits, minimum 1. Counters wrap to 0 at each bit boundary; there is no free-running overflow.
- CLKS_PER_BIT=1 is legal: one bit per cycle, with no idle gap inside the frame.
- All outputs are registered, so tx_line is glitch-free.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx_line = even parity, i.e. the XOR of the latched word, computed at latch time. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic. Frame length is (DATA_W+2)*CLKS_PER_BIT.

Decomposition:
- Package serial_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}, shared with the future receiver;
  - localparams IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module bit_timer:
  - counts to CLKS_PER_BIT-1;
  - outputs a one-cycle bit_done pulse;
  - takes a synchronous restart input asserted on each state entry;
  - uses the same clk and active-low asynchronous reset.

Test Plan:
- Reset check: reset=0 with random tx_data/tx_valid → tx_line=1, tx_ready=1, busy=0 held. Release at a non-edge time → first edge stays IDLE.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, send 8'hA5 → tx_line = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles. busy=1 for 40 cycles; tx_ready=0 throughout.
- Ignored request: while busy, assert tx_valid with 8'hFF → frame in progress unchanged; 8'hFF sent only after tx_ready returns to 1.
- Back-to-back: hold tx_valid=1 with 8'h00 then 8'hFF → exactly one IDLE cycle (tx_line=1) between frame 1's stop bit and frame 2's start bit.
- Mid-frame reset: assert reset=0 during bit 3 of 8'h3C → tx_line=1 immediately (asynchronous). After release, state is IDLE and tx_ready=1.
- Parity build with SERIAL_TX_PARITY_EN, CLKS_PER_BIT=1: send 8'h07 → a parity bit of 1 between data and stop; frame length 11 cycles.
